// File: rtl/reg_file_scoreboard.sv
// Register file with a per-register busy (pending-write) scoreboard.
//
// After reset the block walks every register, zeroing its data and busy bit one per cycle
// (CLEAR), then enters RUN, where it accepts writes and reserves until the next reset.
//
// Ports:
//   Clk_In       - clock, all state updates on the rising edge
//   Reset_n_In   - synchronous active-low reset, restarts clearing from index 0
//   Rd_Addr_In   - packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   Rd_Data_Out  - packed combinational read data, port p at [p*DATA_W +: DATA_W]
//   Rd_Busy_Out  - per-port flag: the addressed register has a pending write
//   Wr_En_In     - write strobe (writes data and clears the busy bit)
//   Wr_Addr_In   - write address
//   Wr_Data_In   - write data
//   Rsv_En_In    - reserve strobe (sets the busy bit of a destination at issue)
//   Rsv_Addr_In  - register to reserve
//   Ready_Out    - high once clearing is done; writes and reserves are accepted only then
module reg_file_scoreboard #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned REG_CNT  = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned RD_PORTS = 2,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                         Clk_In,
   input  logic                         Reset_n_In,
   input  logic [RD_PORTS*ADDR_W-1:0]   Rd_Addr_In,
   output logic [RD_PORTS*DATA_W-1:0]   Rd_Data_Out,
   output logic [RD_PORTS-1:0]          Rd_Busy_Out,
   input  logic                         Wr_En_In,
   input  logic [ADDR_W-1:0]            Wr_Addr_In,
   input  logic [DATA_W-1:0]            Wr_Data_In,
   input  logic                         Rsv_En_In,
   input  logic [ADDR_W-1:0]            Rsv_Addr_In,
   output logic                         Ready_Out
);

   typedef enum logic {StClear, StRun} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0]   regs_q [REG_CNT];
   logic [REG_CNT-1:0]  busy_q;

   logic                wr_ok;
   logic                rsv_ok;

   // True for addresses that map to a real, writable register.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (32'(a) < REG_CNT) && !(ZERO_REG && (a == '0));
   endfunction

   assign Ready_Out = (state_q == StRun);
   assign wr_ok     = Ready_Out && Wr_En_In  && addr_ok(Wr_Addr_In);
   assign rsv_ok    = Ready_Out && Rsv_En_In && addr_ok(Rsv_Addr_In);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         StClear: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (32'(clr_cnt_q) == REG_CNT - 1) begin
               state_d   = StRun;
               clr_cnt_d = '0;
            end
         end
         StRun: begin
            state_d = StRun;
         end
         default: state_d = StClear;
      endcase
   end

   always_ff @(posedge Clk_In) begin
      if (!Reset_n_In) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Storage has no reset of its own; the CLEAR walk zeroes it.
   always_ff @(posedge Clk_In) begin
      if (Reset_n_In) begin
         if (state_q == StClear) begin
            regs_q[clr_cnt_q] <= '0;
            busy_q[clr_cnt_q] <= 1'b0;
         end else begin
            if (wr_ok) begin
               regs_q[Wr_Addr_In] <= Wr_Data_In;
               busy_q[Wr_Addr_In] <= 1'b0;
            end
            // Reserve is assigned last so it wins over a same-address write: it belongs
            // to a younger instruction.
            if (rsv_ok) begin
               busy_q[Rsv_Addr_In] <= 1'b1;
            end
         end
      end
   end

   for (genvar p = 0; p < int'(RD_PORTS); p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit;
      logic              byp;

      assign addr = Rd_Addr_In[p*ADDR_W +: ADDR_W];
      assign hit  = Ready_Out && addr_ok(addr);
      // Bypass tracks only the same-cycle write; a same-cycle reserve is not visible yet.
      assign byp  = wr_ok && (Wr_Addr_In == addr);

      assign Rd_Data_Out[p*DATA_W +: DATA_W] = !hit ? '0 : (byp ? Wr_Data_In : regs_q[addr]);
      assign Rd_Busy_Out[p]                  = hit && !byp && busy_q[addr];
   end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 32, register width in bits.
- REG_CNT, 32, number of architectural registers.
- ADDR_W, 5, address width; SHALL equal ceil(log2(REG_CNT)).
- RD_PORTS, 2, number of independent read ports.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk_In, in, 1, the single clock; all state updates on its rising edge.
- Reset_n_In, in, 1, synchronous, active-low reset.
- Rd_Addr_In, in, RD_PORTS*ADDR_W, packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- Rd_Data_Out, out, RD_PORTS*DATA_W, packed read data; port p uses bits [p*DATA_W +: DATA_W].
- Rd_Busy_Out, out, RD_PORTS, per-port flag: the addressed register has a pending write.
- Wr_En_In, in, 1, write strobe.
- Wr_Addr_In, in, ADDR_W, write address.
- Wr_Data_In, in, DATA_W, write data.
- Rsv_En_In, in, 1, reserve strobe: marks a destination pending at issue.
- Rsv_Addr_In, in, ADDR_W, register to reserve.
- Ready_Out, out, 1, high when clearing is done and the block accepts writes and reserves.

Function
REQ-003 The block SHALL implement a two-state FSM, CLEAR and RUN.
REQ-004 CLEAR: a counter SHALL walk from 0 to REG_CNT-1, zeroing one register and its busy bit per cycle; after index REG_CNT-1 the FSM SHALL go to RUN on the next edge.
REQ-005 Ready_Out SHALL be 0 in CLEAR and 1 in RUN; RUN SHALL be held until reset.
REQ-006 In CLEAR, Wr_En_In and Rsv_En_In SHALL be ignored.
REQ-007 In RUN, Wr_En_In=1 SHALL write Wr_Data_In to Wr_Addr_In at the clock edge and clear that register's busy bit.
REQ-008 In RUN, Rsv_En_In=1 SHALL set the busy bit of Rsv_Addr_In at the clock edge.
REQ-009 Simultaneous write and reserve to the same address: data SHALL be written and the busy bit SHALL end at 1 (the reserve belongs to a younger instruction).
REQ-010 Simultaneous write and reserve to different addresses: both SHALL take effect independently.
REQ-011 With ZERO_REG=1, writes and reserves to address 0 SHALL be discarded; register 0 SHALL always read 0 with busy 0.
REQ-012 Reads SHALL be combinational, with zero-cycle latency.
REQ-013 Read bypass: if Ready_Out=1, Wr_En_In=1, Wr_Addr_In equals port p's address, and the address is nonzero (or ZERO_REG=0), Rd_Data_Out[p] SHALL equal Wr_Data_In and Rd_Busy_Out[p] SHALL be 0.
REQ-014 Bypass SHALL NOT consider the same-cycle reserve; Rd_Busy_Out reflects only registered busy state plus the REQ-013 override.
REQ-015 An address >= REG_CNT SHALL read 0 with busy 0, and writes or reserves to it SHALL be discarded.
REQ-016 In CLEAR, every Rd_Data_Out lane and every Rd_Busy_Out bit SHALL be 0.
REQ-017 Any number of read ports SHALL be able to address the same register in one cycle, each returning identical values.

Reset
REQ-018 When Reset_n_In=0 at a clock edge, the FSM SHALL enter CLEAR with counter 0 and Ready_Out SHALL be 0 from that edge.
REQ-019 Reset asserted in RUN or mid-CLEAR SHALL restart clearing from index 0.
REQ-020 Register contents SHALL NOT be assumed valid until Ready_Out=1; there SHALL be no file-based initialisation.
REQ-021 Ready_Out SHALL rise exactly REG_CNT cycles after the first edge with Reset_n_In=1.

Verification
REQ-022 Reset release -> Ready_Out=0 for exactly 32 cycles (defaults), then 1; reads of all 32 registers return 0 with busy 0.
REQ-023 Reserve x5, then next cycle write x5=0xDEADBEEF while port0 reads x5 -> same cycle data 0xDEADBEEF with busy 0; next cycle busy 0 and data held.
REQ-024 Write x7=0x1234 and reserve x7 in the same cycle -> next cycle x7 reads 0x1234 with busy 1.
REQ-025 Write x0=0xFFFFFFFF and reserve x0 -> x0 reads 0 with busy 0 in all cycles.
REQ-026 Write x3=0xA5A5A5A5, then assert reset at clear index 10 -> Ready_Out stays 0 for 32 further cycles; x3 then reads 0.
REQ-027 RD_PORTS=4, all ports address x9 after write x9=0x55 -> all four lanes return 0x55 with busy 0.
